// File: rtl/fir_sym_serial.sv
// fir_sym_serial: time-multiplexed symmetric linear-phase FIR with decimation.
// One pre-add/MAC per clock over NHALF unique coefficients, then one rounding
// cycle. Optional macro FIR_SAT_EN clamps the result to DW bits and raises
// out_sat; without it the result wraps and out_sat is tied low.
module fir_sym_serial #(
  parameter int DW        = 32,
  parameter int CW        = 17,
  parameter int TAPS      = 127,
  parameter int ACC_W     = 56,
  parameter int OUT_SHIFT = 24,
  parameter int DECIM     = 1,
  localparam int NHALF    = (TAPS + 1) / 2,
  localparam int AW       = $clog2(NHALF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic [CW-1:0]        coef_wdata,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int TW  = $clog2(TAPS);
  localparam int PW  = DW + 1 + CW;
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RSH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : {(ACC_W+1){1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t                  state_r, state_s;
  logic signed [DW-1:0]    x_r [TAPS];
  logic signed [CW-1:0]    c_r [NHALF];
  logic [DCW-1:0]          dcnt_r;
  logic [AW-1:0]           j_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    in_ready_r, busy_r, out_valid_r;
  logic                    in_ready_s, busy_s, out_valid_s;
  logic [DW-1:0]           out_data_r;
  logic                    accept_s, last_s, fire_s, tap_last_s;
  logic [TW-1:0]           lo_idx_s, hi_idx_s;
  logic signed [DW-1:0]    x_lo_s, x_hi_s;
  logic signed [CW-1:0]    coef_s;
  logic signed [DW:0]      pre_s;
  logic signed [PW-1:0]    pre_ext_s, coef_ext_s, prod_s;
  logic signed [ACC_W:0]   sum_s;
  logic [DW-1:0]           res_s;

  assign accept_s   = in_valid && in_ready_r && (state_r == IDLE);
  assign last_s     = (dcnt_r == DCW'(DECIM - 1));
  assign fire_s     = accept_s && last_s;
  assign tap_last_s = (j_r == AW'(NHALF - 1));

  // State register; reset aborts any MAC in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic: IDLE -> MAC on final decimation sample, NHALF MAC cycles, one OUT cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (fire_s) state_s = MAC; else state_s = IDLE;
      MAC:  if (tap_last_s) state_s = OUT; else state_s = MAC;
      OUT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the handshake outputs can be registered.
  always_comb begin
    in_ready_s  = 1'b0;
    busy_s      = 1'b0;
    case (state_s)
      IDLE:    in_ready_s = 1'b1;
      MAC:     busy_s     = 1'b1;
      OUT:     busy_s     = 1'b1;
      default: busy_s     = 1'b0;
    endcase
    if (state_r == OUT) out_valid_s = 1'b1;
    else                out_valid_s = 1'b0;
  end

  // Registered handshake and strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Delay line: shifts only on accepted samples, frozen during MAC/OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) x_r[k] <= '0;
    end else if (accept_s) begin
      x_r[0] <= in_data;
      for (int k = 1; k < TAPS; k++) x_r[k] <= x_r[k-1];
    end
  end

  // Coefficient RAM: writes accepted only in IDLE and for in-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NHALF; k++) c_r[k] <= '0;
    end else if (coef_we && (state_r == IDLE) && ({1'b0, coef_addr} < (AW+1)'(NHALF))) begin
      c_r[coef_addr] <= coef_wdata;
    end
  end

  // Decimation counter, tap index and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_r <= '0;
      j_r    <= '0;
      acc_r  <= '0;
    end else if (accept_s) begin
      if (last_s) begin
        dcnt_r <= '0;
        j_r    <= '0;
        acc_r  <= '0;
      end else begin
        dcnt_r <= dcnt_r + DCW'(1);
      end
    end else if (state_r == MAC) begin
      acc_r <= acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
      j_r   <= tap_last_s ? '0 : j_r + AW'(1);
    end
  end

  assign lo_idx_s = TW'(j_r);
  assign hi_idx_s = TW'(TAPS - 1) - lo_idx_s;
  assign x_lo_s   = x_r[lo_idx_s];
  assign x_hi_s   = x_r[hi_idx_s];
  assign coef_s   = c_r[j_r];

  // Symmetric pre-add; the centre tap has no mirror partner and is not doubled.
  always_comb begin
    if (tap_last_s) pre_s = {x_lo_s[DW-1], x_lo_s};
    else            pre_s = {x_lo_s[DW-1], x_lo_s} + {x_hi_s[DW-1], x_hi_s};
  end

  assign pre_ext_s  = {{CW{pre_s[DW]}}, pre_s};
  assign coef_ext_s = {{(DW+1){coef_s[CW-1]}}, coef_s};
  assign prod_s     = pre_ext_s * coef_ext_s;

  // Round half toward +inf: add half an output LSB, one guard bit avoids overflow.
  assign sum_s = {acc_r[ACC_W-1], acc_r} + RND;

`ifdef FIR_SAT_EN
  logic signed [ACC_W:0]    shr_s;
  logic [ACC_W-DW+1:0]      hi_s;
  logic                     ovf_s;
  logic                     out_sat_r;

  assign shr_s = sum_s >>> OUT_SHIFT;
  assign hi_s  = shr_s[ACC_W:DW-1];
  assign ovf_s = !((&hi_s) || !(|hi_s));

  // Clamp to the DW-bit signed range when the discarded high bits are not a sign extension.
  always_comb begin
    if (ovf_s) begin
      if (shr_s[ACC_W]) res_s = {1'b1, {(DW-1){1'b0}}};
      else              res_s = {1'b0, {(DW-1){1'b1}}};
    end else begin
      res_s = shr_s[DW-1:0];
    end
  end

  // Saturation flag accompanies the out_valid strobe only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               out_sat_r <= 1'b0;
    else if (state_r == OUT)  out_sat_r <= ovf_s;
    else                      out_sat_r <= 1'b0;
  end
  assign out_sat = out_sat_r;
`else
  assign res_s   = DW'(sum_s >>> OUT_SHIFT);
  assign out_sat = 1'b0;
`endif

  // Result register holds its value between OUT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              out_data_r <= '0;
    else if (state_r == OUT) out_data_r <= res_s;
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fir_sym_serial.sv
// Directed bench for fir_sym_serial: three small instances (7-tap, 7-tap with
// decimation by 2, 3-tap with output rounding). Expected values are hand-derived.
module tb_fir_sym_serial;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]       iv, we, rdy, ov, sat, bsy;
  logic [2:0][7:0]  id, od;
  logic [2:0][1:0]  ca;
  logic [2:0][16:0] cd;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fir_sym_serial #(.DW(8), .CW(17), .TAPS(7), .ACC_W(32), .OUT_SHIFT(0), .DECIM(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
    .coef_we(we[0]), .coef_addr(ca[0]), .coef_wdata(cd[0]), .out_valid(ov[0]),
    .out_data(od[0]), .out_sat(sat[0]), .busy(bsy[0]));

  fir_sym_serial #(.DW(8), .CW(17), .TAPS(7), .ACC_W(32), .OUT_SHIFT(0), .DECIM(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
    .coef_we(we[1]), .coef_addr(ca[1]), .coef_wdata(cd[1]), .out_valid(ov[1]),
    .out_data(od[1]), .out_sat(sat[1]), .busy(bsy[1]));

  fir_sym_serial #(.DW(8), .CW(17), .TAPS(3), .ACC_W(32), .OUT_SHIFT(4), .DECIM(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(id[2]),
    .coef_we(we[2]), .coef_addr(ca[2][0:0]), .coef_wdata(cd[2]), .out_valid(ov[2]),
    .out_data(od[2]), .out_sat(sat[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wcoef(input int w, input int addr, input int val);
    @(negedge clk);
    we[w] = 1'b1; ca[w] = 2'(addr); cd[w] = 17'(val);
    @(posedge clk); #1;
    we[w] = 1'b0;
  endtask

  task automatic send(input int w, input int d);
    int guard = 0;
    @(negedge clk);
    while (!rdy[w] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_seen", {63'd0, rdy[w]}, 64'sd1);
    iv[w] = 1'b1; id[w] = 8'(d);
    @(posedge clk); #1;
    iv[w] = 1'b0;
  endtask

  task automatic wait_out(input int w, output int lat, output int low,
                          output logic signed [7:0] d, output logic s);
    int cnt = 0;
    bit seen = 1'b0;
    low = 0;
    while (cnt < 60 && !seen) begin
      @(negedge clk);
      cnt++;
      if (!rdy[w]) low++;
      if (ov[w]) seen = 1'b1;
    end
    chk("out_valid_seen", {63'd0, seen}, 64'sd1);
    lat = seen ? cnt - 1 : -1;
    d   = od[w];
    s   = sat[w];
  endtask

  initial begin
    int lat, low, n;
    logic signed [7:0] d;
    logic s;
    int exp_a [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int rv [5]    = '{24, 23, 8, -8, -24};
    int re [5]    = '{2, 1, 1, 0, -1};

    iv = '0; we = '0; id = '0; ca = '0; cd = '0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, rdy[0]}, 64'sd0);
    chk("rst_out_valid", {63'd0, ov[0]}, 64'sd0);
    chk("rst_out_data", $signed(od[0]), 64'sd0);
    chk("rst_busy", {63'd0, bsy[0]}, 64'sd0);
    chk("rst_out_sat", {63'd0, sat[0]}, 64'sd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {63'd0, rdy[0]}, 64'sd1);

    for (int k = 0; k < 4; k++) wcoef(0, k, k + 1);
    for (int k = 0; k < 4; k++) wcoef(1, k, 1);
    wcoef(2, 0, 0);
    wcoef(2, 1, 1);

    // Impulse response 1,2,3,4,3,2,1,0 with fixed latency
    for (int i = 0; i < 8; i++) begin
      send(0, (i == 0) ? 1 : 0);
      wait_out(0, lat, low, d, s);
      chk("impulse_data", d, exp_a[i]);
      chk("impulse_latency", lat, 5);
      if (i == 0) begin
        chk("ready_low_cycles", low, 5);
        chk("sat_normal", {63'd0, s}, 64'sd0);
        @(negedge clk);
        chk("valid_single_cycle", {63'd0, ov[0]}, 64'sd0);
        chk("data_hold", $signed(od[0]), 64'sd1);
      end
    end

    // Write during MAC is dropped: x0=5 -> 5, then x0=2,x1=5 -> 1*2+2*5 = 12
    send(0, 5);
    @(negedge clk);
    chk("busy_in_mac", {63'd0, bsy[0]}, 64'sd1);
    we[0] = 1'b1; ca[0] = 2'd0; cd[0] = 17'd9;
    @(posedge clk); #1;
    we[0] = 1'b0;
    wait_out(0, lat, low, d, s);
    chk("mac_write_res1", d, 5);
    send(0, 2);
    wait_out(0, lat, low, d, s);
    chk("mac_write_dropped", d, 12);

    // Write and accept on the same edge: x=1,2,5 -> 9*1+2*2+3*5 = 28
    @(negedge clk);
    chk("idle_ready", {63'd0, rdy[0]}, 64'sd1);
    we[0] = 1'b1; ca[0] = 2'd0; cd[0] = 17'd9;
    iv[0] = 1'b1; id[0] = 8'd1;
    @(posedge clk); #1;
    we[0] = 1'b0; iv[0] = 1'b0;
    wait_out(0, lat, low, d, s);
    chk("same_edge_write", d, 28);

    // Saturation: all coefficients 127, input 127 -> acc = 112903
    for (int k = 0; k < 4; k++) wcoef(0, k, 127);
    for (int i = 0; i < 7; i++) begin
      send(0, 127);
      wait_out(0, lat, low, d, s);
    end
`ifdef FIR_SAT_EN
    chk("sat_data", d, 127);
    chk("sat_flag", {63'd0, s}, 64'sd1);
`else
    chk("wrap_data", d, 7);
    chk("wrap_flag", {63'd0, s}, 64'sd0);
`endif

    // Decimation by 2 with constant 1: output on every 2nd sample
    for (n = 1; n <= 10; n++) begin
      send(1, 1);
      if ((n % 2) == 1) begin
        @(negedge clk);
        chk("decim_no_valid", {63'd0, ov[1]}, 64'sd0);
        chk("decim_stay_idle", {63'd0, rdy[1]}, 64'sd1);
      end else begin
        wait_out(1, lat, low, d, s);
        chk("decim_data", d, (n < 7) ? n : 7);
        chk("decim_latency", lat, 5);
      end
    end

    // Rounding, 3 taps, centre coefficient 1, shift 4
    for (int i = 0; i < 5; i++) begin
      send(2, rv[i]);
      wait_out(2, lat, low, d, s);
      send(2, rv[i]);
      wait_out(2, lat, low, d, s);
      chk("round_data", d, re[i]);
      if (i == 0) chk("round_latency", lat, 3);
    end

    // Reset in the middle of a MAC sequence
    send(0, 7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bsy[0]}, 64'sd0);
    chk("abort_ready", {63'd0, rdy[0]}, 64'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    low = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) low++;
    end
    chk("abort_no_valid", low, 0);
    for (int i = 0; i < 3; i++) begin
      send(0, 100 - 30 * i);
      wait_out(0, lat, low, d, s);
      chk("coef_cleared", d, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
